// File: rtl/demux_pkg.sv
// Shared defaults and lane-index constants for the 1-to-2 buffered demux.
package demux_pkg;

   localparam int   DEMUX_WIDTH = 4;
   localparam int   DEMUX_CNT_W = 8;

   localparam logic LANE_A = 1'b0;
   localparam logic LANE_B = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// One output lane: a single-entry holding register with valid flag,
// load/drain control and a wrapping delivered-word counter.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH,
   parameter int CNT_W = DEMUX_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic             o_space,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_data_p1;
   logic             r_vld_p1;
   logic [CNT_W-1:0] r_count;
   logic             w_drain;

   assign w_drain = r_vld_p1 & i_ready;

   // A full lane that drains this cycle can take a new word on the same edge.
   assign o_space = ~r_vld_p1 | i_ready;

   // Stage p1: holding register, valid flag and delivered-word counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_p1 <= '0;
         r_vld_p1  <= 1'b0;
         r_count   <= '0;
      end else begin
         if (i_load) begin
            r_data_p1 <= i_data;
            r_vld_p1  <= 1'b1;
         end else if (w_drain) begin
            r_vld_p1  <= 1'b0;
         end
         if (w_drain) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign o_data  = r_data_p1;
   assign o_valid = r_vld_p1;
   assign o_count = r_count;

endmodule

// File: rtl/demux_1_2_buf.sv
// 1-to-2 demultiplexer with a one-word buffer per lane; the top level only
// decodes select and muxes the selected lane's space into in_ready.
module demux_1_2_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = DEMUX_WIDTH,
   parameter int CNT_W = DEMUX_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             select,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_a_data,
   output logic [WIDTH-1:0] out_b_data,
   output logic             out_a_valid,
   output logic             out_b_valid,
   input  logic             out_a_ready,
   input  logic             out_b_ready,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b
);

   logic w_space_a;
   logic w_space_b;
   logic w_in_ready;
   logic w_accept;
   logic w_load_a;
   logic w_load_b;

   // Only the selected lane's space matters; the other lane never stalls input.
   assign w_in_ready = ~reset & ((select == LANE_B) ? w_space_b : w_space_a);
   assign w_accept   = in_valid & w_in_ready;
   assign w_load_a   = w_accept & (select == LANE_A);
   assign w_load_b   = w_accept & (select == LANE_B);
   assign in_ready   = w_in_ready;

   demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot_a (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load_a),
      .i_data  (in_data),
      .i_ready (out_a_ready),
      .o_space (w_space_a),
      .o_data  (out_a_data),
      .o_valid (out_a_valid),
      .o_count (count_a)
   );

   demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot_b (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load_b),
      .i_data  (in_data),
      .i_ready (out_b_ready),
      .o_space (w_space_b),
      .o_data  (out_b_data),
      .o_valid (out_b_valid),
      .o_count (count_b)
   );

endmodule

// File: tb/tb_demux_1_2_buf.sv
// Bench for demux_1_2_buf: directed vector table, corner sequences and a
// randomized run against per-lane queue models.
module tb_demux_1_2_buf;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             select;
   logic             in_ready;
   logic [WIDTH-1:0] out_a_data;
   logic [WIDTH-1:0] out_b_data;
   logic             out_a_valid;
   logic             out_b_valid;
   logic             out_a_ready;
   logic             out_b_ready;
   logic [CNT_W-1:0] count_a;
   logic [CNT_W-1:0] count_b;

   int num_correct = 0;
   int num_wrong   = 0;

   always #5 clk = ~clk;

   demux_1_2_buf #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .select      (select),
      .in_ready    (in_ready),
      .out_a_data  (out_a_data),
      .out_b_data  (out_b_data),
      .out_a_valid (out_a_valid),
      .out_b_valid (out_b_valid),
      .out_a_ready (out_a_ready),
      .out_b_ready (out_b_ready),
      .count_a     (count_a),
      .count_b     (count_b)
   );

   typedef struct {
      logic       v;
      logic       sel;
      logic [3:0] d;
      logic       ar;
      logic       br;
      logic       exp_rdy;
      logic       exp_av;
      logic [3:0] exp_ad;
      logic       exp_bv;
      logic [3:0] exp_bd;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act === exp) begin
         num_correct++;
      end else begin
         num_wrong++;
         $display("FAIL %s ASSERTION ERROR at t=%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic sel, input logic [3:0] d,
                        input logic ar, input logic br);
      in_valid    = v;
      select      = sel;
      in_data     = d;
      out_a_ready = ar;
      out_b_ready = br;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   logic [3:0] qa[$];
   logic [3:0] qb[$];
   logic [3:0] sb[$];
   int unsigned ma_cnt;
   int unsigned mb_cnt;
   logic        exp_rdy;
   logic        pop_a;
   logic        pop_b;
   logic [3:0]  w;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0};
      vecs[1] = '{1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 4'h0};
      vecs[2] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 4'h5};
      vecs[3] = '{1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h5};
      vecs[4] = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0};
      vecs[5] = '{1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 4'h0};
      vecs[6] = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 4'h0};
      vecs[7] = '{1'b1, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h9};

      // Reset state, observed while reset is still asserted
      reset = 1'b1;
      drive(1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_a_valid", out_a_valid, 0);
      chk("rst_b_valid", out_b_valid, 0);
      chk("rst_a_data", out_a_data, 0);
      chk("rst_b_data", out_b_data, 0);
      chk("rst_count_a", count_a, 0);
      chk("rst_count_b", count_b, 0);
      reset = 1'b0;

      // Directed vector table, applied back to back from the reset state
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ar, vecs[i].br);
         #1;
         chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
         tick();
         chk($sformatf("vec%0d_a_valid", i), out_a_valid, vecs[i].exp_av);
         chk($sformatf("vec%0d_b_valid", i), out_b_valid, vecs[i].exp_bv);
         if (vecs[i].exp_av) chk($sformatf("vec%0d_a_data", i), out_a_data, vecs[i].exp_ad);
         if (vecs[i].exp_bv) chk($sformatf("vec%0d_b_data", i), out_b_data, vecs[i].exp_bd);
      end

      // Simultaneous drain and load on a full lane
      do_reset();
      drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
      tick();
      chk("reload_a_first", out_a_data, 4'h3);
      drive(1'b1, 1'b0, 4'h7, 1'b1, 1'b0);
      #1;
      chk("reload_in_ready", in_ready, 1);
      tick();
      chk("reload_a_data", out_a_data, 4'h7);
      chk("reload_a_valid", out_a_valid, 1);
      chk("reload_count_a", count_a, 1);

      // 256-word stream on lane B: counter wraps, order preserved
      do_reset();
      sb.delete();
      for (int i = 0; i < 256; i++) begin
         w = 4'(i * 7 + 3);
         drive(1'b1, 1'b1, w, 1'b0, 1'b1);
         #1;
         chk("stream_in_ready", in_ready, 1);
         if (i > 0) begin
            chk("stream_b_valid", out_b_valid, 1);
            chk("stream_b_data", out_b_data, sb.pop_front());
         end
         sb.push_back(w);
         tick();
      end
      drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
      #1;
      chk("stream_last_data", out_b_data, sb.pop_front());
      chk("stream_count_b_255", count_b, 255);
      tick();
      chk("stream_count_b_wrap", count_b, 0);
      chk("stream_b_empty", out_b_valid, 0);
      chk("stream_count_a", count_a, 0);

      // Reset mid-operation with both lanes full
      do_reset();
      drive(1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 4'hD, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b1, 4'h6, 1'b0, 1'b0);
      tick();
      chk("pre_rst_both_full", {out_a_valid, out_b_valid}, 2'b11);
      chk("pre_rst_count_a", count_a, 1);
      reset = 1'b1;
      drive(1'b1, 1'b0, 4'hE, 1'b1, 1'b1);
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      tick();
      chk("mid_rst_in_ready_after", in_ready, 0);
      chk("mid_rst_valids", {out_a_valid, out_b_valid}, 2'b00);
      chk("mid_rst_a_data", out_a_data, 0);
      chk("mid_rst_b_data", out_b_data, 0);
      chk("mid_rst_count_a", count_a, 0);
      chk("mid_rst_count_b", count_b, 0);
      reset = 1'b0;

      // Randomized run against per-lane one-deep queue models
      qa.delete();
      qb.delete();
      ma_cnt = 0;
      mb_cnt = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         reset = (cyc == 0) || ($urandom_range(0, 299) == 0);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
         #1;
         if (reset)       exp_rdy = 1'b0;
         else if (select) exp_rdy = (qb.size() == 0) || out_b_ready;
         else             exp_rdy = (qa.size() == 0) || out_a_ready;
         chk("rand_in_ready", in_ready, exp_rdy);
         chk("rand_a_valid", out_a_valid, qa.size() != 0);
         chk("rand_b_valid", out_b_valid, qb.size() != 0);
         if (qa.size() != 0) chk("rand_a_data", out_a_data, qa[0]);
         if (qb.size() != 0) chk("rand_b_data", out_b_data, qb[0]);
         chk("rand_count_a", count_a, ma_cnt % 256);
         chk("rand_count_b", count_b, mb_cnt % 256);
         if (reset) begin
            qa.delete();
            qb.delete();
            ma_cnt = 0;
            mb_cnt = 0;
         end else begin
            pop_a = (qa.size() != 0) && out_a_ready;
            pop_b = (qb.size() != 0) && out_b_ready;
            if (pop_a) begin
               void'(qa.pop_front());
               ma_cnt++;
            end
            if (pop_b) begin
               void'(qb.pop_front());
               mb_cnt++;
            end
            if (in_valid && exp_rdy) begin
               if (select) qb.push_back(in_data);
               else        qa.push_back(in_data);
            end
         end
         tick();
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", num_correct, num_correct + num_wrong);
      $finish;
   end

endmodule
